// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: header byte offsets, receive FSM states and header payload.
package eth_pkg;

    localparam int unsigned SRC_OFF  = 6;
    localparam int unsigned TYPE_OFF = 12;
    localparam int unsigned PAY_OFF  = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DST,
        ST_SRC,
        ST_TYPE,
        ST_PAY,
        ST_DROP
    } rx_state_e;

    typedef struct packed {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] etype;
    } eth_hdr_t;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/eth_rx_parser.sv
// Byte-serial Ethernet receive parser: extracts DA/SA/EtherType, forwards payload with
// one cycle of latency, discards runts/oversize/aborted frames and counts outcomes.
module eth_rx_parser
    import eth_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 1500,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_sof,
    input  logic             rx_eof,
    output logic [47:0]      dest_mac,
    output logic [47:0]      src_mac,
    output logic [15:0]      ethertype,
    output logic             hdr_valid,
    output logic [7:0]       payload,
    output logic             tx_valid,
    output logic             tx_last,
    output logic             frame_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // Shared header-index / payload-length counter; must reach MAX_PAYLOAD+1.
    localparam int unsigned PCNT_W = $clog2(MAX_PAYLOAD + 2);
    localparam int unsigned BCNT_W = (PCNT_W > 4) ? PCNT_W : 4;

    rx_state_e         state_q;
    logic [BCNT_W-1:0] cnt_q;
    logic [47:0]       sh_dest_q;
    logic [47:0]       sh_src_q;
    logic [7:0]        sh_type_hi_q;
    eth_hdr_t          hdr_q;
    logic              hdr_valid_q;
    logic [7:0]        payload_q;
    logic              tx_valid_q;
    logic              tx_last_q;
    logic              frame_err_q;
    logic              good_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sh_dest_q    <= '0;
            sh_src_q     <= '0;
            sh_type_hi_q <= '0;
            hdr_q        <= '0;
            hdr_valid_q  <= 1'b0;
            payload_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_last_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            good_q       <= 1'b0;
        end else begin
            hdr_valid_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            frame_err_q <= 1'b0;
            good_q      <= 1'b0;
            if (rx_valid) begin
                if (rx_sof) begin
                    // A new frame always wins; abandoning a live frame is an error.
                    if ((state_q != ST_IDLE) && (state_q != ST_DROP)) begin
                        frame_err_q <= 1'b1;
                    end
                    sh_dest_q <= {sh_dest_q[39:0], rx_data};
                    cnt_q     <= BCNT_W'(1);
                    if (rx_eof) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_DST;
                    end
                end else begin
                    case (state_q)
                        ST_IDLE: ;
                        ST_DST: begin
                            sh_dest_q <= {sh_dest_q[39:0], rx_data};
                            cnt_q     <= cnt_q + BCNT_W'(1);
                            if (rx_eof) begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_IDLE;
                            end else if (cnt_q == BCNT_W'(SRC_OFF - 1)) begin
                                state_q <= ST_SRC;
                            end
                        end
                        ST_SRC: begin
                            sh_src_q <= {sh_src_q[39:0], rx_data};
                            cnt_q    <= cnt_q + BCNT_W'(1);
                            if (rx_eof) begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_IDLE;
                            end else if (cnt_q == BCNT_W'(TYPE_OFF - 1)) begin
                                state_q <= ST_TYPE;
                            end
                        end
                        ST_TYPE: begin
                            if (cnt_q == BCNT_W'(PAY_OFF - 2)) begin
                                sh_type_hi_q <= rx_data;
                                cnt_q        <= cnt_q + BCNT_W'(1);
                                if (rx_eof) begin
                                    frame_err_q <= 1'b1;
                                    state_q     <= ST_IDLE;
                                end
                            end else begin
                                // Last header byte: publish all fields together.
                                hdr_q       <= '{dest: sh_dest_q, src: sh_src_q,
                                                 etype: {sh_type_hi_q, rx_data}};
                                hdr_valid_q <= 1'b1;
                                cnt_q       <= '0;
                                if (rx_eof) begin
                                    good_q  <= 1'b1;
                                    state_q <= ST_IDLE;
                                end else begin
                                    state_q <= ST_PAY;
                                end
                            end
                        end
                        ST_PAY: begin
                            if (cnt_q == BCNT_W'(MAX_PAYLOAD)) begin
                                frame_err_q <= 1'b1;
                                state_q     <= rx_eof ? ST_IDLE : ST_DROP;
                            end else begin
                                payload_q  <= rx_data;
                                tx_valid_q <= 1'b1;
                                tx_last_q  <= rx_eof;
                                cnt_q      <= cnt_q + BCNT_W'(1);
                                if (rx_eof) begin
                                    good_q  <= 1'b1;
                                    state_q <= ST_IDLE;
                                end
                            end
                        end
                        ST_DROP: begin
                            if (rx_eof) begin
                                state_q <= ST_IDLE;
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_good_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (good_q),
        .count (good_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (frame_err_q),
        .count (err_cnt)
    );

    assign dest_mac  = hdr_q.dest;
    assign src_mac   = hdr_q.src;
    assign ethertype = hdr_q.etype;
    assign hdr_valid = hdr_valid_q;
    assign payload   = payload_q;
    assign tx_valid  = tx_valid_q;
    assign tx_last   = tx_last_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_eth_rx_parser.sv
// Randomised and directed bench for eth_rx_parser against a frame-level reference model.
module tb_eth_rx_parser;

    localparam int unsigned MAXP = 4;
    localparam int unsigned CW   = 3;

    logic          clk;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_sof;
    logic          rx_eof;
    logic [47:0]   dest_mac;
    logic [47:0]   src_mac;
    logic [15:0]   ethertype;
    logic          hdr_valid;
    logic [7:0]    payload;
    logic          tx_valid;
    logic          tx_last;
    logic          frame_err;
    logic [CW-1:0] good_cnt;
    logic [CW-1:0] err_cnt;

    eth_rx_parser #(.MAX_PAYLOAD(MAXP), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_sof    (rx_sof),
        .rx_eof    (rx_eof),
        .dest_mac  (dest_mac),
        .src_mac   (src_mac),
        .ethertype (ethertype),
        .hdr_valid (hdr_valid),
        .payload   (payload),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .frame_err (frame_err),
        .good_cnt  (good_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the frame is a byte list; its length decides what each byte means.
    logic [7:0]    fb[$];
    bit            m_in, m_drop;
    logic [47:0]   e_dest, e_src;
    logic [15:0]   e_type;
    logic [7:0]    e_pay;
    bit            e_hdrv, e_txv, e_last, e_ferr, e_gpulse;
    logic [CW-1:0] e_good, e_err;

    task automatic model_byte(input logic [7:0] d, input logic s, input logic e);
        int n;
        if (s) begin
            if (m_in && !m_drop) e_ferr = 1'b1;
            fb.delete();
            fb.push_back(d);
            m_in = 1'b1;
            m_drop = 1'b0;
            if (e) begin e_ferr = 1'b1; m_in = 1'b0; end
        end else if (m_in && m_drop) begin
            if (e) m_in = 1'b0;
        end else if (m_in) begin
            fb.push_back(d);
            n = fb.size();
            if (n < 14) begin
                if (e) begin e_ferr = 1'b1; m_in = 1'b0; end
            end else if (n == 14) begin
                for (int i = 0; i < 6; i++) begin
                    e_dest = {e_dest[39:0], fb[i]};
                    e_src  = {e_src[39:0], fb[i+6]};
                end
                e_type = {fb[12], fb[13]};
                e_hdrv = 1'b1;
                if (e) begin e_gpulse = 1'b1; m_in = 1'b0; end
            end else if (n - 14 > int'(MAXP)) begin
                e_ferr = 1'b1;
                m_drop = 1'b1;
                if (e) m_in = 1'b0;
            end else begin
                e_pay  = d;
                e_txv  = 1'b1;
                e_last = e;
                if (e) begin e_gpulse = 1'b1; m_in = 1'b0; end
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            fb.delete();
            m_in = 0; m_drop = 0;
            e_dest = '0; e_src = '0; e_type = '0; e_pay = '0;
            e_hdrv = 0; e_txv = 0; e_last = 0; e_ferr = 0; e_gpulse = 0;
            e_good = '0; e_err = '0;
        end else begin
            if (e_gpulse && e_good != '1) e_good = e_good + 1'b1;
            if (e_ferr && e_err != '1) e_err = e_err + 1'b1;
            e_hdrv = 0; e_txv = 0; e_last = 0; e_ferr = 0; e_gpulse = 0;
            if (rx_valid) model_byte(rx_data, rx_sof, rx_eof);
        end
    end

    logic [7:0] cap[$];
    int         n_last, n_hdr;
    logic [7:0] last_pay;

    always @(negedge clk) begin
        if (run_chk) begin
            chk("dest_mac",  64'(dest_mac),  64'(e_dest));
            chk("src_mac",   64'(src_mac),   64'(e_src));
            chk("ethertype", 64'(ethertype), 64'(e_type));
            chk("hdr_valid", 64'(hdr_valid), 64'(e_hdrv));
            chk("tx_valid",  64'(tx_valid),  64'(e_txv));
            chk("tx_last",   64'(tx_last),   64'(e_last));
            chk("payload",   64'(payload),   64'(e_pay));
            chk("frame_err", 64'(frame_err), 64'(e_ferr));
            chk("good_cnt",  64'(good_cnt),  64'(e_good));
            chk("err_cnt",   64'(err_cnt),   64'(e_err));
            if (tx_valid) begin
                cap.push_back(payload);
                if (tx_last) begin n_last++; last_pay = payload; end
            end
            if (hdr_valid) n_hdr++;
        end
    end

    logic [7:0] fr[$];

    task automatic cyc(input logic v, input logic [7:0] d, input logic s, input logic e);
        @(negedge clk);
        rx_valid = v; rx_data = d; rx_sof = s; rx_eof = e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cap.delete(); n_last = 0; n_hdr = 0; last_pay = '0;
    endtask

    task automatic build(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] ty);
        logic [111:0] h;
        h = {da, sa, ty};
        fr.delete();
        for (int i = 13; i >= 0; i--) fr.push_back(h[i*8 +: 8]);
    endtask

    // gap: 0 back-to-back, 1 every other cycle idle, 2 random idles
    task automatic send(input int gap, input bit do_eof);
        for (int i = 0; i < fr.size(); i++) begin
            cyc(1'b1, fr[i], i == 0, do_eof && (i == fr.size() - 1));
            if (gap == 1) idle(1);
            else if (gap == 2) idle(int'($urandom_range(0, 2)));
        end
    endtask

    task automatic check_basic(input string p);
        idle(3);
        chk({p, "_dest"}, 64'(dest_mac), 64'h010203040506);
        chk({p, "_src"}, 64'(src_mac), 64'h0A0B0C0D0E0F);
        chk({p, "_type"}, 64'(ethertype), 64'h0800);
        chk({p, "_good"}, 64'(good_cnt), 64'd1);
        chk({p, "_nbytes"}, 64'(cap.size()), 64'd3);
        chk({p, "_seq"}, 64'({cap[0], cap[1], cap[2]}), 64'hAABBCC);
        chk({p, "_last"}, 64'(last_pay), 64'hCC);
        chk({p, "_nlast"}, 64'(n_last), 64'd1);
        chk({p, "_nhdr"}, 64'(n_hdr), 64'd1);
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_sof = 1'b0; rx_eof = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        run_chk = 1'b1;
        do_reset();
        chk("rst_good", 64'(good_cnt), 64'd0);
        chk("rst_dest", 64'(dest_mac), 64'd0);

        // Basic good frame, then the same frame with gaps
        build(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800);
        fr.push_back(8'hAA); fr.push_back(8'hBB); fr.push_back(8'hCC);
        send(0, 1'b1);
        check_basic("good");
        do_reset();
        send(1, 1'b1);
        check_basic("gap");

        // Runt with eof on byte 9
        do_reset();
        fr = fr[0:9];
        send(0, 1'b1);
        idle(3);
        chk("runt_err", 64'(err_cnt), 64'd1);
        chk("runt_dest", 64'(dest_mac), 64'd0);
        chk("runt_ntx", 64'(cap.size()), 64'd0);

        // Oversize payload, then a normal frame
        do_reset();
        build(48'h112233445566, 48'h778899AABBCC, 16'h88B5);
        for (int i = 0; i < 6; i++) fr.push_back(8'(8'h11 + i));
        send(0, 1'b1);
        idle(2);
        chk("ovr_nfwd", 64'(cap.size()), 64'd4);
        chk("ovr_nlast", 64'(n_last), 64'd0);
        chk("ovr_err", 64'(err_cnt), 64'd1);
        fr = fr[0:15];
        send(0, 1'b1);
        idle(2);
        chk("ovr_good", 64'(good_cnt), 64'd1);
        chk("ovr_type", 64'(ethertype), 64'h88B5);

        // sof on payload byte 2 aborts, second frame is good
        do_reset();
        build(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0806);
        fr.push_back(8'h01); fr.push_back(8'h02);
        send(0, 1'b0);
        build(48'hC1C2C3C4C5C6, 48'hD1D2D3D4D5D6, 16'h86DD);
        fr.push_back(8'h33);
        send(0, 1'b1);
        idle(2);
        chk("abort_err", 64'(err_cnt), 64'd1);
        chk("abort_good", 64'(good_cnt), 64'd1);
        chk("abort_dest", 64'(dest_mac), 64'hC1C2C3C4C5C6);
        chk("abort_nlast", 64'(n_last), 64'd1);

        // Reset mid-payload
        build(48'h0000000000AB, 48'h0000000000CD, 16'h1234);
        fr.push_back(8'h55); fr.push_back(8'h66);
        send(0, 1'b0);
        do_reset();
        chk("midrst_txv", 64'(tx_valid), 64'd0);
        chk("midrst_err", 64'(err_cnt), 64'd0);
        chk("midrst_type", 64'(ethertype), 64'd0);
        build(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800);
        fr.push_back(8'hAA); fr.push_back(8'hBB); fr.push_back(8'hCC);
        send(2, 1'b1);
        check_basic("midrst");

        // Junk in IDLE, sof+eof runt, zero-payload frame
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 1'b0, i == 4);
        cyc(1'b1, 8'h77, 1'b1, 1'b1);
        build(48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 16'h0042);
        send(0, 1'b1);
        idle(2);
        chk("zp_err", 64'(err_cnt), 64'd1);
        chk("zp_good", 64'(good_cnt), 64'd1);
        chk("zp_ntx", 64'(cap.size()), 64'd0);
        chk("zp_nhdr", 64'(n_hdr), 64'd1);

        // Random traffic; counters are narrow so they must saturate
        do_reset();
        for (int f = 0; f < 400; f++) begin
            int plen, mode, len;
            build({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom));
            plen = int'($urandom_range(0, 7));
            for (int i = 0; i < plen; i++) fr.push_back(8'($urandom));
            mode = int'($urandom_range(0, 7));
            if (mode == 6) begin
                len = int'($urandom_range(2, fr.size()));
                fr = fr[0:len-1];
                send(int'($urandom_range(0, 2)), 1'b1);
            end else if (mode == 7) begin
                len = int'($urandom_range(1, fr.size()));
                fr = fr[0:len-1];
                send(int'($urandom_range(0, 2)), 1'b0);
            end else begin
                send(int'($urandom_range(0, 2)), 1'b1);
            end
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                    cyc(1'b1, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            end
            idle(int'($urandom_range(0, 2)));
        end
        idle(3);
        chk("sat_good", 64'(good_cnt), 64'd7);
        chk("sat_err", 64'(err_cnt), 64'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
